// File: rtl/gpr_dump_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gpr_dump_if: register-file read port plus dump output stream.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface gpr_dump_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          out_last;

  modport master (
    output rd_addr,
    input  rd_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_idx,
    output out_last
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_idx,
    input  out_last
  );
endinterface
`default_nettype wire

// File: rtl/gpr_dump.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gpr_dump: streams registers 0..NREG-1 out with a running XOR sum. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module gpr_dump #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  gpr_dump_if.master        bus,
  output logic              busy_o,
  output logic              done_o,
  output logic [DW-1:0]     checksum_o
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [AW-1:0] out_idx_q, out_idx_d;
  logic [DW-1:0] checksum_q, checksum_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
      checksum_q <= checksum_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    checksum_d = checksum_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          state_d    = S_FETCH;
          idx_d      = '0;
          checksum_d = '0;
        end
      end
      S_FETCH: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          out_data_d = bus.rd_data;
          out_idx_d  = idx_q;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        // abort takes priority: a word offered during abort is never counted
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (bus.out_ready) begin
          checksum_d = checksum_q ^ out_data_q;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.rd_addr   = idx_q;
  assign bus.out_valid = (state_q == S_SEND);
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = (state_q == S_SEND) && (out_idx_q == LAST_IDX);
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign checksum_o    = checksum_q;

endmodule
`default_nettype wire

// File: tb/tb_gpr_dump.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_gpr_dump: scoreboard bench for gpr_dump (NREG=32 and NREG=4).  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_gpr_dump;
  localparam int NREG = 32;
  localparam int DW   = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ready = 1'b1;
  logic start4 = 1'b0;
  logic busy, done, busy4, done4;
  logic [DW-1:0] checksum, checksum4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;
  int stall_cnt = 0;
  bit stalled7 = 1'b0;
  int done_cnt = 0;
  word_t exp_q[$];

  gpr_dump_if #(.DW(DW), .AW(AW)) ifc ();
  gpr_dump_if #(.DW(DW), .AW(2))  ifc4 ();

  function automatic logic [DW-1:0] regv(input int i);
    return DW'(i) * 32'h0101_0101;
  endfunction

  function automatic logic [DW-1:0] xor_upto(input int n);
    logic [DW-1:0] x = '0;
    for (int i = 0; i < n; i++) x ^= regv(i);
    return x;
  endfunction

  assign ifc.rd_data   = regv(int'(ifc.rd_addr));
  assign ifc.out_ready = ready;
  assign ifc4.rd_data  = regv(int'(ifc4.rd_addr));
  assign ifc4.out_ready = 1'b1;

  gpr_dump #(.NREG(NREG), .DW(DW), .AW(AW)) u_dut (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .bus(ifc.master),
    .busy_o(busy), .done_o(done), .checksum_o(checksum)
  );

  gpr_dump #(.NREG(4), .DW(DW), .AW(2)) u_dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .abort_i(1'b0), .bus(ifc4.master),
    .busy_o(busy4), .done_o(done4), .checksum_o(checksum4)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ready generator: always-ready, or random with a one-shot 5-cycle stall on idx 7
  initial forever begin
    @(posedge clk);
    #1;
    if (ready_mode == 0) ready = 1'b1;
    else if (stall_cnt > 0) begin
      ready = 1'b0;
      stall_cnt--;
    end else if (ifc.out_valid && ifc.out_idx == 5'd7 && !stalled7) begin
      stalled7  = 1'b1;
      stall_cnt = 4;
      ready     = 1'b0;
    end else ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops the scoreboard on every accepted word
  initial begin
    logic          hold_pend = 1'b0;
    logic [DW-1:0] hold_data = '0;
    logic [AW-1:0] hold_idx = '0;
    word_t         e;
    forever begin
      @(negedge clk);
      if (!rst) hold_pend = 1'b0;
      else begin
        if (ifc.out_valid) begin
          if (hold_pend) begin
            chk("hold_data", 64'(ifc.out_data), 64'(hold_data));
            chk("hold_idx", 64'(ifc.out_idx), 64'(hold_idx));
          end
          if (exp_q.size() == 0) fail_now("unexpected_word");
          else begin
            e = exp_q[0];
            chk("out_idx", 64'(ifc.out_idx), 64'(e.idx));
            chk("out_data", 64'(ifc.out_data), 64'(e.data));
            chk("out_last", 64'(ifc.out_last), 64'(e.last));
            chk("rd_addr", 64'(ifc.rd_addr), 64'(e.idx));
            if (ifc.out_ready && !abort) void'(exp_q.pop_front());
          end
          hold_pend = !(ifc.out_ready && !abort);
          hold_data = ifc.out_data;
          hold_idx  = ifc.out_idx;
        end else begin
          chk("last_low", 64'(ifc.out_last), 64'd0);
          hold_pend = 1'b0;
        end
        if (done) begin
          done_cnt++;
          chk("done_queue_empty", 64'(exp_q.size()), 64'd0);
        end
      end
    end
  end

  task automatic issue_start();
    start = 1'b1;
    for (int i = 0; i < NREG; i++) exp_q.push_back('{AW'(i), regv(i), (i == NREG - 1)});
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, input bit check_lat);
    int n = 0;
    while (!done && n < 5000) begin
      tick();
      n++;
    end
    if (!done) fail_now("done_timeout");
    else if (check_lat) chk("done_latency", 64'(cyc - c0), 64'(2 * NREG + 1));
    chk("checksum_full", 64'(checksum), 64'(xor_upto(NREG)));
    tick();
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
  endtask

  // Returns once the DUT is presenting word k (in_send) or fetching it
  task automatic wait_word(input int k, input bit in_send);
    bit ok = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      tick();
      if (exp_q.size() == NREG - k && (in_send ? ifc.out_valid : !ifc.out_valid)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("wait_word_timeout");
  endtask

  task automatic do_abort(input int k);
    int d0;
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("busy_after_abort", 64'(busy), 64'd0);
    chk("valid_after_abort", 64'(ifc.out_valid), 64'd0);
    exp_q.delete();
    repeat (3) tick();
    chk("no_done_after_abort", 64'(done_cnt), 64'(d0));
    chk("checksum_abort", 64'(checksum), 64'(xor_upto(k)));
  endtask

  initial begin
    int c0, d0, k, w;
    bit got_done;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_rd_addr", 64'(ifc.rd_addr), 64'd0);
    chk("rst_checksum", 64'(checksum), 64'd0);
    #3 rst = 1'b1;
    tick();
    chk("post_rst_done", 64'(done), 64'd0);
    chk("post_rst_last", 64'(ifc.out_last), 64'd0);
    chk("post_rst_out_data", 64'(ifc.out_data), 64'd0);

    // Full dump with out_ready held high
    c0 = cyc;
    issue_start();
    wait_done(c0, 1'b1);
    repeat (3) tick();
    chk("checksum_hold_idle", 64'(checksum), 64'(xor_upto(NREG)));
    chk("out_idx_hold_idle", 64'(ifc.out_idx), 64'(NREG - 1));

    // Random back-pressure with a 5-cycle stall on idx 7
    ready_mode = 1;
    stalled7   = 1'b0;
    c0 = cyc;
    issue_start();
    wait_done(c0, 1'b0);
    ready_mode = 0;

    // Abort in SEND of idx 10 with out_ready high, then a fresh dump
    issue_start();
    wait_word(10, 1'b1);
    do_abort(10);
    c0 = cyc;
    issue_start();
    wait_done(c0, 1'b1);

    // start re-pulsed while busy, then start+abort together in IDLE
    c0 = cyc;
    issue_start();
    wait_word(3, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(c0, 1'b1);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle_busy", 64'(busy), 64'd0);
    tick();
    chk("start_abort_idle_checksum", 64'(checksum), 64'(xor_upto(NREG)));

    // Reset pulled in FETCH of idx 20
    d0 = done_cnt;
    issue_start();
    wait_word(20, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_rd_addr", 64'(ifc.rd_addr), 64'd0);
    chk("midrst_out_idx", 64'(ifc.out_idx), 64'd0);
    chk("midrst_out_data", 64'(ifc.out_data), 64'd0);
    chk("midrst_checksum", 64'(checksum), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    exp_q.delete();
    tick();
    #2 rst = 1'b1;
    tick();
    chk("midrst_no_done", 64'(done_cnt), 64'(d0));
    c0 = cyc;
    issue_start();
    wait_done(c0, 1'b1);

    // Randomized dumps with random back-pressure and optional abort point
    ready_mode = 1;
    repeat (4) begin
      stalled7 = 1'b0;
      k = int'($urandom_range(1, NREG - 1));
      issue_start();
      if ($urandom_range(0, 1) == 1) begin
        wait_word(k, 1'b1);
        do_abort(k);
      end else wait_done(cyc, 1'b0);
    end
    ready_mode = 0;
    repeat (2) tick();

    // NREG=4 instance
    w = 0;
    got_done = 1'b0;
    start4 = 1'b1;
    c0 = cyc;
    tick();
    start4 = 1'b0;
    for (int n = 0; n < 50 && !got_done; n++) begin
      if (ifc4.out_valid) begin
        chk("n4_idx", 64'(ifc4.out_idx), 64'(w));
        chk("n4_data", 64'(ifc4.out_data), 64'(regv(w)));
        chk("n4_last", 64'(ifc4.out_last), 64'(w == 3));
        w++;
      end
      if (done4) begin
        got_done = 1'b1;
        chk("n4_latency", 64'(cyc - c0), 64'd9);
        chk("n4_words", 64'(w), 64'd4);
        chk("n4_checksum", 64'(checksum4), 64'(xor_upto(4)));
      end else tick();
    end
    if (!got_done) fail_now("n4_done_timeout");
    tick();
    chk("n4_busy_after", 64'(busy4), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/gpr_dump.md
GPR_DUMP -- requirements
Module: gpr_dump

Interface
REQ-001 Parameter NREG, default 32, number of registers scanned (indices 0..NREG-1).
REQ-002 Parameter DW, default 32, register data width.
REQ-003 Parameter AW, default 5, register index width; NREG SHALL NOT exceed 2**AW.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  single-cycle request to begin a dump, honoured only in IDLE.
REQ-007 abort  input  1  cancels a dump in progress.
REQ-008 rd_addr  output  AW  read index to the register file read port.
REQ-009 rd_data  input  DW  combinational read data for rd_addr; index 0 reads zero.
REQ-010 out_valid  output  1  out_data/out_idx are valid.
REQ-011 out_ready  input  1  sink accepts the word when out_valid is also high.
REQ-012 out_data  output  DW  captured register value.
REQ-013 out_idx  output  AW  index of out_data.
REQ-014 out_last  output  1  high with out_valid when out_idx == NREG-1.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse after the last word is accepted.
REQ-017 checksum  output  DW  XOR of all words accepted in the current/most recent dump.

Function
REQ-018 FSM states IDLE, FETCH, SEND, DONE, registered, one state per cycle minimum.
REQ-019 IDLE: start=1 and abort=0 -> FETCH, idx <= 0, checksum <= 0; otherwise stay in IDLE.
REQ-020 FETCH: rd_addr = idx; out_data <= rd_data and out_idx <= idx on the clock edge; -> SEND.
REQ-021 SEND: out_valid=1; out_data, out_idx, out_last held stable until the handshake completes.
REQ-022 Transfer occurs on a cycle where out_valid & out_ready; checksum <= checksum ^ out_data on that edge.
REQ-023 SEND with transfer: idx == NREG-1 -> DONE; otherwise idx <= idx+1, -> FETCH.
REQ-024 SEND without transfer: stay in SEND, no state change.
REQ-025 DONE: done=1 for exactly that cycle; -> IDLE unconditionally.
REQ-026 rd_addr SHALL equal idx in all states (no glitching to other indices).
REQ-027 Latency: start accepted at edge N -> out_valid high in the cycle after edge N+1; with out_ready held high, one word every 2 cycles; full dump of NREG words ends with done pulse 2*NREG+1 cycles after start.
REQ-028 start while busy SHALL be ignored (no restart, no checksum clear).
REQ-029 abort while busy -> IDLE on the next edge; out_valid low from then; no done pulse; checksum holds the XOR of words already transferred.
REQ-030 abort and start in the same IDLE cycle: abort wins, stay in IDLE.
REQ-031 abort during SEND on the same cycle as out_ready: the word does not count as transferred; checksum not updated.
REQ-032 idx SHALL never exceed NREG-1; no wrap to 0 within a dump.
REQ-033 out_valid SHALL be low in IDLE, FETCH, DONE; out_last SHALL be low whenever out_valid is low.
REQ-034 checksum, out_data, out_idx SHALL hold their values in IDLE after completion or abort until the next accepted start.

Reset
REQ-035 rst low asynchronously forces state IDLE, idx 0, out_data 0, out_idx 0, checksum 0.
REQ-036 During and right after reset: out_valid 0, out_last 0, busy 0, done 0, rd_addr 0.
REQ-037 Reset asserted mid-dump SHALL cancel it with no done pulse; first start after rst high begins a fresh dump from index 0.

Verification
REQ-038 Register model reg[i]=i*0x01010101 (reg[0]=0), out_ready tied 1, start pulse -> 32 words idx 0..31 with matching data, out_last only on idx 31, done at cycle 65 after start, checksum = XOR of all 32 values.
REQ-039 out_ready toggled randomly (including 5-cycle stalls on idx 7) -> data/idx held stable while stalled, no word duplicated or skipped, same checksum as REQ-038.
REQ-040 abort asserted in SEND of idx 10 -> busy low next cycle, no done, checksum = XOR of reg[0..9]; next start dumps from idx 0.
REQ-041 start re-pulsed in SEND of idx 3 and start+abort together in IDLE -> no restart, no effect respectively.
REQ-042 rst pulled low in FETCH of idx 20 -> all outputs at reset values immediately, no done; dump after release correct.
REQ-043 NREG=4 build -> 4 words idx 0..3, out_last on idx 3, done 9 cycles after start.
